// File: rtl/vcve2_vex_seq_if.sv
// Operation type and port bundle for the vector element sequencer.
// The master modport is the sequencer; the slave modport is its environment.
package vcve2_vex_seq_pkg;

  typedef enum logic [2:0] {
    VALU_MOVE = 3'd0,
    VALU_ADD  = 3'd1,
    VALU_SUB  = 3'd2,
    VALU_AND  = 3'd3,
    VALU_OR   = 3'd4,
    VALU_XOR  = 3'd5
  } valu_op_e;

endpackage

interface vcve2_vex_seq_if #(
  parameter int ELEN = 32,
  parameter int VLEN = 128,
  parameter int NREG = 32
);
  import vcve2_vex_seq_pkg::*;

  localparam int NUM_ELEM = VLEN / ELEN;
  localparam int VLW      = $clog2(NUM_ELEM) + 1;
  localparam int IW       = VLW - 1;
  localparam int RW       = $clog2(NREG);

  logic            vinstr_valid_i;
  logic            vinstr_ready_o;
  logic [RW-1:0]   vs1_i;
  logic [RW-1:0]   vs2_i;
  logic [RW-1:0]   vd_i;
  logic [VLW-1:0]  vl_i;
  valu_op_e        valu_op_i;

  logic [RW-1:0]   vrf_raddr_a_o;
  logic [RW-1:0]   vrf_raddr_b_o;
  logic [IW-1:0]   vrf_ridx_o;
  logic [ELEN-1:0] vrf_rdata_a_i;
  logic [ELEN-1:0] vrf_rdata_b_i;

  logic [ELEN-1:0] valu_operand_a_o;
  logic [ELEN-1:0] valu_operand_b_o;
  logic [ELEN-1:0] valu_operand_c_o;
  valu_op_e        valu_operator_o;
  logic [ELEN-1:0] vec_result_ex_i;

  logic            vrf_we_o;
  logic [RW-1:0]   vrf_waddr_o;
  logic [IW-1:0]   vrf_widx_o;
  logic [ELEN-1:0] vrf_wdata_o;

  logic            vinstr_done_o;
  logic [31:0]     elem_cnt_o;

  modport master (
    input  vinstr_valid_i, vs1_i, vs2_i, vd_i, vl_i, valu_op_i,
    input  vrf_rdata_a_i, vrf_rdata_b_i, vec_result_ex_i,
    output vinstr_ready_o,
    output vrf_raddr_a_o, vrf_raddr_b_o, vrf_ridx_o,
    output valu_operand_a_o, valu_operand_b_o, valu_operand_c_o, valu_operator_o,
    output vrf_we_o, vrf_waddr_o, vrf_widx_o, vrf_wdata_o,
    output vinstr_done_o, elem_cnt_o
  );

  modport slave (
    output vinstr_valid_i, vs1_i, vs2_i, vd_i, vl_i, valu_op_i,
    output vrf_rdata_a_i, vrf_rdata_b_i, vec_result_ex_i,
    input  vinstr_ready_o,
    input  vrf_raddr_a_o, vrf_raddr_b_o, vrf_ridx_o,
    input  valu_operand_a_o, valu_operand_b_o, valu_operand_c_o, valu_operator_o,
    input  vrf_we_o, vrf_waddr_o, vrf_widx_o, vrf_wdata_o,
    input  vinstr_done_o, elem_cnt_o
  );

endinterface

// File: rtl/vcve2_vex_seq.sv
// Vector element sequencer: walks elements 0..vl-1 through VRF read, VALU and writeback.
// Define VCVE2_VEX_SEQ_PERF_EN to get a free-running count of element writes on elem_cnt_o.
module vcve2_vex_seq #(
  parameter int ELEN = 32,
  parameter int VLEN = 128,
  parameter int NREG = 32
) (
  input logic clk_i,
  input logic rst_ni,
  vcve2_vex_seq_if.master bus
);
  import vcve2_vex_seq_pkg::*;

  localparam int NUM_ELEM = VLEN / ELEN;
  localparam int VLW      = $clog2(NUM_ELEM) + 1;
  localparam int IW       = VLW - 1;
  localparam int RW       = $clog2(NREG);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state_q;
  logic [RW-1:0]  vs1_q;
  logic [RW-1:0]  vs2_q;
  logic [RW-1:0]  vd_q;
  valu_op_e       op_q;
  logic [VLW-1:0] vl_q;
  logic [IW-1:0]  ridx_q;
  logic [IW-1:0]  widx_q;
  logic           pend_q;

  logic [VLW-1:0] vl_clamped;
  logic           accept;
  logic           last_read;
  logic           in_run;

  assign vl_clamped = (bus.vl_i > VLW'(NUM_ELEM)) ? VLW'(NUM_ELEM) : bus.vl_i;
  assign accept     = (state_q == IDLE) && bus.vinstr_valid_i;
  assign in_run     = (state_q == RUN);
  assign last_read  = ({1'b0, ridx_q} == (vl_q - VLW'(1)));

  // pend_q marks that a read was issued last cycle, so this cycle writes back its result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      op_q    <= VALU_MOVE;
      vl_q    <= '0;
      ridx_q  <= '0;
      widx_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (accept) begin
            vs1_q  <= bus.vs1_i;
            vs2_q  <= bus.vs2_i;
            vd_q   <= bus.vd_i;
            op_q   <= bus.valu_op_i;
            vl_q   <= vl_clamped;
            ridx_q <= '0;
            state_q <= (vl_clamped == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          pend_q <= 1'b1;
          widx_q <= ridx_q;
          ridx_q <= ridx_q + IW'(1);
          if (last_read) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.vinstr_ready_o = (state_q == IDLE);
  assign bus.vinstr_done_o  = (state_q == DRAIN);

  assign bus.vrf_raddr_a_o = in_run ? vs1_q  : '0;
  assign bus.vrf_raddr_b_o = in_run ? vs2_q  : '0;
  assign bus.vrf_ridx_o    = in_run ? ridx_q : '0;

  // Operands and write port are forced to zero whenever no element is in flight
  assign bus.valu_operand_a_o = pend_q ? bus.vrf_rdata_a_i : '0;
  assign bus.valu_operand_b_o = pend_q ? bus.vrf_rdata_b_i : '0;
  assign bus.valu_operand_c_o = '0;
  assign bus.valu_operator_o  = pend_q ? op_q : VALU_MOVE;

  assign bus.vrf_we_o    = pend_q;
  assign bus.vrf_waddr_o = pend_q ? vd_q : '0;
  assign bus.vrf_widx_o  = pend_q ? widx_q : '0;
  assign bus.vrf_wdata_o = pend_q ? bus.vec_result_ex_i : '0;

`ifdef VCVE2_VEX_SEQ_PERF_EN
  logic [31:0] elem_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_cnt_q <= '0;
    end else if (pend_q) begin
      elem_cnt_q <= elem_cnt_q + 32'd1;
    end
  end

  assign bus.elem_cnt_o = elem_cnt_q;
`else
  assign bus.elem_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vcve2_vex_seq.sv
// Directed bench for vcve2_vex_seq with a behavioural VRF and VALU around it.
module tb_vcve2_vex_seq;
  import vcve2_vex_seq_pkg::*;

  logic clk_i;
  logic rst_ni;

  int vectors_applied = 0;
  int miscompares     = 0;
  int exp_elem        = 0;

  logic [31:0] exp_data [4];
  logic [31:0] vrf [32][4];

  logic        load_en;
  logic [4:0]  load_reg;
  logic [1:0]  load_idx;
  logic [31:0] load_data;

  vcve2_vex_seq_if #(.ELEN(32), .VLEN(128), .NREG(32)) bus ();

  vcve2_vex_seq #(.ELEN(32), .VLEN(128), .NREG(32)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural VRF: synchronous read, write port, and a preload path for setup
  always @(posedge clk_i) begin
    if (load_en) begin
      vrf[load_reg][load_idx] <= load_data;
    end else if (bus.vrf_we_o) begin
      vrf[bus.vrf_waddr_o][bus.vrf_widx_o] <= bus.vrf_wdata_o;
    end
    bus.vrf_rdata_a_i <= vrf[bus.vrf_raddr_a_o][bus.vrf_ridx_o];
    bus.vrf_rdata_b_i <= vrf[bus.vrf_raddr_b_o][bus.vrf_ridx_o];
  end

  always_comb begin
    bus.vec_result_ex_i = bus.valu_operand_a_o;
    case (bus.valu_operator_o)
      VALU_ADD: bus.vec_result_ex_i = bus.valu_operand_a_o + bus.valu_operand_b_o;
      VALU_SUB: bus.vec_result_ex_i = bus.valu_operand_a_o - bus.valu_operand_b_o;
      VALU_AND: bus.vec_result_ex_i = bus.valu_operand_a_o & bus.valu_operand_b_o;
      VALU_OR:  bus.vec_result_ex_i = bus.valu_operand_a_o | bus.valu_operand_b_o;
      VALU_XOR: bus.vec_result_ex_i = bus.valu_operand_a_o ^ bus.valu_operand_b_o;
      default:  bus.vec_result_ex_i = bus.valu_operand_a_o;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic loadReg(input logic [4:0] r, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      load_en   = 1'b1;
      load_reg  = r;
      load_idx  = 2'(i);
      load_data = d[i];
    end
    @(negedge clk_i);
    load_en = 1'b0;
  endtask

  // Offers one instruction at a negedge and returns at the negedge after the accept edge
  task automatic applyStimulus(input valu_op_e op, input logic [4:0] vs1, input logic [4:0] vs2,
                               input logic [4:0] vd, input logic [2:0] vl);
    int wait_cnt = 0;
    while (!bus.vinstr_ready_o && wait_cnt < 20) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    if (!bus.vinstr_ready_o) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.vinstr_valid_i = 1'b1;
    bus.valu_op_i      = op;
    bus.vs1_i          = vs1;
    bus.vs2_i          = vs2;
    bus.vd_i           = vd;
    bus.vl_i           = vl;
    @(negedge clk_i);
    bus.vinstr_valid_i = 1'b0;
  endtask

  // Cycle-by-cycle check of one instruction; k counts cycles after the accept cycle T
  task automatic runInstr(input string name, input valu_op_e op, input logic [4:0] vs1,
                          input logic [4:0] vs2, input logic [4:0] vd, input logic [2:0] vl,
                          input int n_eff);
    logic wr_exp;
    applyStimulus(op, vs1, vs2, vd, vl);
    for (int k = 1; k <= n_eff + 2; k++) begin
      wr_exp = (k >= 2) && (k <= n_eff + 1);
      checkOutput($sformatf("%s_we_k%0d", name, k), 32'(bus.vrf_we_o), 32'(wr_exp));
      checkOutput($sformatf("%s_done_k%0d", name, k), 32'(bus.vinstr_done_o),
                  32'(k == n_eff + 1));
      checkOutput($sformatf("%s_ready_k%0d", name, k), 32'(bus.vinstr_ready_o),
                  32'(k >= n_eff + 2));
      checkOutput($sformatf("%s_op_k%0d", name, k), 32'(bus.valu_operator_o),
                  wr_exp ? 32'(op) : 32'(VALU_MOVE));
      if (k <= n_eff) begin
        checkOutput($sformatf("%s_raddr_a_k%0d", name, k), 32'(bus.vrf_raddr_a_o), 32'(vs1));
        checkOutput($sformatf("%s_raddr_b_k%0d", name, k), 32'(bus.vrf_raddr_b_o), 32'(vs2));
        checkOutput($sformatf("%s_ridx_k%0d", name, k), 32'(bus.vrf_ridx_o), 32'(k - 1));
      end
      if (wr_exp) begin
        checkOutput($sformatf("%s_waddr_k%0d", name, k), 32'(bus.vrf_waddr_o), 32'(vd));
        checkOutput($sformatf("%s_widx_k%0d", name, k), 32'(bus.vrf_widx_o), 32'(k - 2));
        checkOutput($sformatf("%s_wdata_k%0d", name, k), bus.vrf_wdata_o, exp_data[k - 2]);
      end
      if (k <= n_eff) begin
        bus.vinstr_valid_i = 1'b1;
        bus.vs1_i          = 5'($urandom);
        bus.vs2_i          = 5'($urandom);
        bus.vd_i           = 5'($urandom);
        bus.vl_i           = 3'($urandom);
        bus.valu_op_i      = VALU_XOR;
      end else begin
        bus.vinstr_valid_i = 1'b0;
      end
      if (k < n_eff + 2) @(negedge clk_i);
    end
    exp_elem += n_eff;
`ifdef VCVE2_VEX_SEQ_PERF_EN
    checkOutput({name, "_elem_cnt"}, bus.elem_cnt_o, 32'(exp_elem));
`else
    checkOutput({name, "_elem_cnt"}, bus.elem_cnt_o, 32'd0);
`endif
  endtask

  initial begin
    rst_ni             = 1'b0;
    load_en            = 1'b0;
    load_reg           = '0;
    load_idx           = '0;
    load_data          = '0;
    bus.vinstr_valid_i = 1'b0;
    bus.vs1_i          = '0;
    bus.vs2_i          = '0;
    bus.vd_i           = '0;
    bus.vl_i           = '0;
    bus.valu_op_i      = VALU_MOVE;
    for (int r = 0; r < 32; r++) loadReg(5'(r), 32'd0, 32'd0, 32'd0, 32'd0);
    loadReg(5'd1, 32'd1, 32'd2, 32'd3, 32'd4);
    loadReg(5'd2, 32'd10, 32'd20, 32'd30, 32'd40);
    loadReg(5'd4, 32'd1, 32'd1, 32'd1, 32'd1);
    loadReg(5'd5, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0);
    loadReg(5'd7, 32'd5, 32'd6, 32'd7, 32'd8);
    loadReg(5'd8, 32'd1, 32'd1, 32'd1, 32'd1);
    loadReg(5'd9, 32'd2, 32'd2, 32'd2, 32'd2);

    checkOutput("rst_ready", 32'(bus.vinstr_ready_o), 32'd1);
    checkOutput("rst_we", 32'(bus.vrf_we_o), 32'd0);
    checkOutput("rst_done", 32'(bus.vinstr_done_o), 32'd0);
    checkOutput("rst_elem_cnt", bus.elem_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    exp_data = '{32'd11, 32'd22, 32'd33, 32'd44};
    runInstr("add4", VALU_ADD, 5'd1, 5'd2, 5'd3, 3'd4, 4);

    exp_data = '{32'hDEADBEEF, 32'd0, 32'd0, 32'd0};
    runInstr("move1", VALU_MOVE, 5'd5, 5'd0, 5'd6, 3'd1, 1);

    runInstr("vl0", VALU_ADD, 5'd1, 5'd2, 5'd12, 3'd0, 0);

    exp_data = '{32'd4, 32'd5, 32'd6, 32'd7};
    runInstr("vl7", VALU_SUB, 5'd7, 5'd8, 5'd13, 3'd7, 4);

    exp_data = '{32'd3, 32'd3, 32'd3, 32'd3};
    runInstr("inplace", VALU_ADD, 5'd4, 5'd9, 5'd4, 3'd4, 4);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("inplace_vrf_idx%0d", i), vrf[4][i], 32'd3);
    end
    checkOutput("move1_vrf", vrf[6][0], 32'hDEADBEEF);

    // Asynchronous reset in the middle of a vl=4 instruction
    applyStimulus(VALU_ADD, 5'd1, 5'd2, 5'd14, 3'd4);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(bus.vinstr_ready_o), 32'd1);
    checkOutput("midrst_we", 32'(bus.vrf_we_o), 32'd0);
    checkOutput("midrst_wdata", bus.vrf_wdata_o, 32'd0);
    checkOutput("midrst_done", 32'(bus.vinstr_done_o), 32'd0);
    checkOutput("midrst_raddr_a", 32'(bus.vrf_raddr_a_o), 32'd0);
    checkOutput("midrst_operand_a", bus.valu_operand_a_o, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("midrst_hold_we%0d", i), 32'(bus.vrf_we_o), 32'd0);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("postrst_elem_cnt", bus.elem_cnt_o, 32'd0);
    exp_elem = 0;

    exp_data = '{32'd11, 32'd22, 32'd33, 32'd44};
    runInstr("postrst", VALU_ADD, 5'd1, 5'd2, 5'd10, 3'd4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/vcve2_vex_seq.md
# vcve2_vex_seq

Vector element sequencer that sits directly upstream of the vector execution block. It accepts one decoded vector instruction at a time and walks its elements from 0 to vl-1. For each element it reads source operands from the vector register file (VRF), drives the combinational VALU operand/operator inputs, and writes the VALU result back to the VRF. Throughput is one element per cycle, with a one-cycle read-to-writeback pipeline.

## Interface
Parameters:
- ELEN, 32, element width in bits
- VLEN, 128, vector register width in bits; NUM_ELEM = VLEN/ELEN (default 4); VLW = $clog2(NUM_ELEM)+1
- NREG, 32, number of vector registers; RW = $clog2(NREG)

Ports:
- clk_i  in  1  clock; one clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- vinstr_valid_i  in  1  instruction offered
- vinstr_ready_o  out  1  instruction accepted when valid&&ready
- vs1_i, vs2_i, vd_i  in  RW each  source/destination register indices
- vl_i  in  VLW  element count; values above NUM_ELEM clamp to NUM_ELEM
- valu_op_i  in  valu_op_e  operation
- vrf_raddr_a_o, vrf_raddr_b_o  out  RW  VRF read register addresses (vs1, vs2)
- vrf_ridx_o  out  VLW-1  element index for both read ports
- vrf_rdata_a_i, vrf_rdata_b_i  in  ELEN  VRF read data, valid one cycle after address
- valu_operand_a_o, valu_operand_b_o, valu_operand_c_o  out  ELEN  to VALU; c tied 0
- valu_operator_o  out  valu_op_e  latched operation
- vec_result_ex_i  in  ELEN  VALU combinational result
- vrf_we_o  out  1  write enable
- vrf_waddr_o  out  RW; vrf_widx_o  out  VLW-1; vrf_wdata_o  out  ELEN  write port
- vinstr_done_o  out  1  single-cycle completion pulse
- elem_cnt_o  out  32  elements written since reset (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN. Registered fields: vs1/vs2/vd/op/vl (clamped), ridx_q, pend_q (read issued last cycle), widx_q.
- IDLE: ready=1. On accept: latch fields and set ridx_q=0. If clamped vl=0, go to DRAIN with pend_q=0. Otherwise go to RUN.
- RUN: drive raddr_a=vs1, raddr_b=vs2, ridx=ridx_q. Set pend_q=1, widx_q=ridx_q, then ridx_q++. If ridx_q==vl-1, go to DRAIN.
- Writeback, in any state with pend_q=1: operand_a/b = rdata_a/b; we=1, waddr=vd, widx=widx_q, wdata=vec_result_ex_i.
- DRAIN: performs the final pending write if pend_q=1. Pulses done, clears pend_q, goes to IDLE.
- Reads of element i and the write of element i-1 occur in the same cycle. Because these are different elements, vd==vs1/vs2 overlap is hazard-free.
- valu_operator_o = latched op while pend_q=1, else VALU_MOVE. Operands are 0 when pend_q=0.
- Reset (including mid-instruction): state=IDLE, pend_q=0, ridx_q=widx_q=0, all outputs 0 except ready=1; no partial writes complete.

## Timing
- Accept at cycle T, vl=N≥1: reads occur at T+1..T+N and writes at T+2..T+N+1.
- done asserts at T+N+1, coincident with the last write. ready reasserts at T+N+2.
- vl=0: done at T+1, no writes, ready at T+2.
- ready=0 throughout RUN/DRAIN. valid while not ready is ignored, and inputs may change freely.
- No back-to-back overlap: the minimum spacing between accepts is N+2 cycles.

## Configuration
- VCVE2_VEX_SEQ_PERF_EN defined: elem_cnt_o is a 32-bit counter, reset to 0, that increments on every cycle with vrf_we_o=1 and wraps from 0xFFFFFFFF to 0.
- VCVE2_VEX_SEQ_PERF_EN undefined: elem_cnt_o is tied to 0 and no counter flops exist.

## Test plan
- VALU_ADD, vs1=1 holding {1,2,3,4}, vs2=2 holding {10,20,30,40}, vd=3, vl=4 -> writes idx0..3 = {11,22,33,44} at T+2..T+5; done at T+5; ready at T+6; elem_cnt_o=4 (PERF_EN).
- VALU_MOVE, vl=1, vs1=5 elem0=0xDEADBEEF, vd=6 -> a single write of 0xDEADBEEF to vd=6 idx0 at T+2; done at T+2.
- vl=0 -> no vrf_we_o; done at T+1; ready at T+2.
- vl=7 (above NUM_ELEM=4) -> exactly 4 writes, idx 0..3.
- In-place add, vd=vs1=4 holding {1,1,1,1}, vs2 holding {2,2,2,2} -> vd={3,3,3,3}, no corruption.
- rst_ni low at T+3 of a vl=4 instruction -> outputs 0 and ready=1 immediately; no further writes. A new instruction after release completes normally, with elem_cnt_o=0 before it starts.
